// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, legality and class decode,
// and the issue-sequencer state encoding.
package alu_pkg;

   localparam logic [4:0] OP_ADD    = 5'd0;
   localparam logic [4:0] OP_SUB    = 5'd1;
   localparam logic [4:0] OP_AND    = 5'd2;
   localparam logic [4:0] OP_OR     = 5'd3;
   localparam logic [4:0] OP_XOR    = 5'd4;
   localparam logic [4:0] OP_SLL    = 5'd5;
   localparam logic [4:0] OP_SRL    = 5'd6;
   localparam logic [4:0] OP_SRA    = 5'd7;
   localparam logic [4:0] OP_SLT    = 5'd8;
   localparam logic [4:0] OP_SLTU   = 5'd9;
   localparam logic [4:0] OP_MULH   = 5'd16;
   localparam logic [4:0] OP_MULHSU = 5'd17;
   localparam logic [4:0] OP_MULHU  = 5'd18;
   localparam logic [4:0] OP_MUL    = 5'd22;
   localparam logic [4:0] OP_DIV    = 5'd24;
   localparam logic [4:0] OP_DIVU   = 5'd26;
   localparam logic [4:0] OP_REM    = 5'd28;
   localparam logic [4:0] OP_REMU   = 5'd30;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      CAPT = 2'd2,
      RESP = 2'd3
   } seq_state_t;

   typedef enum logic [1:0] {
      CLS_SIMPLE = 2'd0,
      CLS_MUL    = 2'd1,
      CLS_DIV    = 2'd2
   } op_class_t;

   // True for every opcode the ALU implements.
   function automatic logic op_is_legal(input logic [4:0] op);
      logic legal;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
         OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
         OP_MULH, OP_MULHSU, OP_MULHU, OP_MUL,
         OP_DIV, OP_DIVU, OP_REM, OP_REMU: legal = 1'b1;
         default:                          legal = 1'b0;
      endcase
      return legal;
   endfunction

   // Latency class; divide ops are recognised by their two top opcode bits.
   function automatic op_class_t op_class(input logic [4:0] op);
      op_class_t cls;
      if (op[4:3] == 2'b11) begin
         cls = CLS_DIV;
      end else if (op == OP_MULH || op == OP_MULHSU || op == OP_MULHU || op == OP_MUL) begin
         cls = CLS_MUL;
      end else begin
         cls = CLS_SIMPLE;
      end
      return cls;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The pointer remembers the slot that
// was last granted; on a tie the other slot wins, so continuous demand
// from both slots alternates strictly.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] grant,
   output logic       gnt_id
);

   logic ptr_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_grant
         localparam int OTHER = 1 - gi;
         // A slot wins when it is alone, or when it was not the last one served.
         assign grant[gi] = en & req[gi] & (~req[OTHER] | (ptr_reg != 1'(gi)));
      end
   endgenerate

   assign gnt_id = grant[1];

   // Pointer follows each grant, which is always an accept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_reg <= 1'b0;
      end else if (|grant) begin
         ptr_reg <= grant[1];
      end
   end

endmodule

// File: rtl/alu_issue_sequencer.sv
// Shares one ALU between two issue slots. Each accepted op holds its
// operands on the ALU inputs for the op's class latency (multicycle
// mul/div paths), waits one extra cycle for the ALU output register,
// then returns the result with its tag on a valid/ready channel.
// Optional flush port is enabled by defining ALU_SEQ_FLUSH_EN.
module alu_issue_sequencer
   import alu_pkg::*;
#(
   parameter int TAG_W      = 4,
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 8
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef ALU_SEQ_FLUSH_EN
   input  logic             flush,
`endif
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [4:0]       req0_aluop,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [4:0]       req1_aluop,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   input  logic [TAG_W-1:0] req1_tag,
   output logic [4:0]       alu_op_o,
   output logic [31:0]      alu_in1_o,
   output logic [31:0]      alu_in2_o,
   input  logic [31:0]      alu_out_i,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [31:0]      rsp_data,
   output logic             rsp_err
);

   localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
   localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   seq_state_t       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [4:0]       op_reg;
   logic [31:0]      a_reg, b_reg;
   logic [TAG_W-1:0] tag_reg;
   logic             id_reg;
   logic [31:0]      rsp_data_reg;
   logic             rsp_err_reg;

   logic             arb_en;
   logic [1:0]       grant;
   logic             gnt_id;
   logic             accept;
   logic [4:0]       sel_op;
   logic [31:0]      sel_a, sel_b;
   logic [TAG_W-1:0] sel_tag;
   logic             sel_legal;
   logic [CNT_W-1:0] sel_cnt;

   // Arbitration is only open in IDLE; a flush there also closes it.
`ifdef ALU_SEQ_FLUSH_EN
   assign arb_en = (state_reg == IDLE) & ~flush;
`else
   assign arb_en = (state_reg == IDLE);
`endif

   rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (arb_en),
      .req    ({req1_valid, req0_valid}),
      .grant  (grant),
      .gnt_id (gnt_id)
   );

   assign accept = |grant;

   // Mux the granted slot's payload and derive its hold count.
   always_comb begin
      sel_op    = gnt_id ? req1_aluop : req0_aluop;
      sel_a     = gnt_id ? req1_a     : req0_a;
      sel_b     = gnt_id ? req1_b     : req0_b;
      sel_tag   = gnt_id ? req1_tag   : req0_tag;
      sel_legal = op_is_legal(sel_op);
      case (op_class(sel_op))
         CLS_DIV: sel_cnt = CNT_W'(DIV_CYCLES - 1);
         CLS_MUL: sel_cnt = CNT_W'(MUL_CYCLES - 1);
         default: sel_cnt = '0;
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: IDLE -> EXEC -> CAPT -> RESP, illegal ops go straight to RESP.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept) state_next = sel_legal ? EXEC : RESP;
         EXEC: if (cnt_reg == '0) state_next = CAPT;
         CAPT: state_next = RESP;
         RESP: if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
`ifdef ALU_SEQ_FLUSH_EN
      if (flush && state_reg != IDLE) state_next = IDLE;
`endif
   end

   // Operand, counter and response registers. Illegal ops leave the ALU
   // inputs untouched so nothing downstream sees spurious activity.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_reg      <= '0;
         op_reg       <= '0;
         a_reg        <= '0;
         b_reg        <= '0;
         tag_reg      <= '0;
         id_reg       <= 1'b0;
         rsp_data_reg <= '0;
         rsp_err_reg  <= 1'b0;
      end else begin
         if (accept) begin
            tag_reg <= sel_tag;
            id_reg  <= gnt_id;
            if (sel_legal) begin
               op_reg  <= sel_op;
               a_reg   <= sel_a;
               b_reg   <= sel_b;
               cnt_reg <= sel_cnt;
            end else begin
               rsp_data_reg <= '0;
               rsp_err_reg  <= 1'b1;
            end
         end
         if (state_reg == EXEC && cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
         end
         if (state_reg == CAPT) begin
            rsp_data_reg <= alu_out_i;
            rsp_err_reg  <= 1'b0;
         end
      end
   end

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign alu_op_o   = op_reg;
   assign alu_in1_o  = a_reg;
   assign alu_in2_o  = b_reg;
   assign rsp_valid  = (state_reg == RESP);
   assign rsp_id     = id_reg;
   assign rsp_tag    = tag_reg;
   assign rsp_data   = rsp_data_reg;
   assign rsp_err    = rsp_err_reg;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed bench for alu_issue_sequencer with a small registered ALU model.
module tb_alu_issue_sequencer;

   logic        clk;
   logic        rst_n;
`ifdef ALU_SEQ_FLUSH_EN
   logic        flush;
`endif
   logic        req0_valid, req0_ready;
   logic [4:0]  req0_aluop;
   logic [31:0] req0_a, req0_b;
   logic [3:0]  req0_tag;
   logic        req1_valid, req1_ready;
   logic [4:0]  req1_aluop;
   logic [31:0] req1_a, req1_b;
   logic [3:0]  req1_tag;
   logic [4:0]  alu_op_o;
   logic [31:0] alu_in1_o, alu_in2_o;
   logic [31:0] alu_out_i;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [3:0]  rsp_tag;
   logic [31:0] rsp_data;

   int vectors;
   int miscompares;

   alu_issue_sequencer #(.TAG_W(4), .MUL_CYCLES(2), .DIV_CYCLES(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef ALU_SEQ_FLUSH_EN
      .flush      (flush),
`endif
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_aluop (req0_aluop),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_tag   (req0_tag),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_aluop (req1_aluop),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_tag   (req1_tag),
      .alu_op_o   (alu_op_o),
      .alu_in1_o  (alu_in1_o),
      .alu_in2_o  (alu_in2_o),
      .alu_out_i  (alu_out_i),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_tag    (rsp_tag),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] r;
      case (op)
         5'd0:    r = x + y;
         5'd1:    r = x - y;
         5'd22:   r = x * y;
         5'd24:   r = (y == 32'd0) ? 32'hFFFF_FFFF : 32'($signed(x) / $signed(y));
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   // Registered ALU result, as the real core ALU presents it.
   always @(posedge clk) alu_out_i <= alu_model(alu_op_o, alu_in1_o, alu_in2_o);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
`ifdef ALU_SEQ_FLUSH_EN
      flush = 1'b0;
`endif
      req0_valid = 1'b0; req0_aluop = '0; req0_a = '0; req0_b = '0; req0_tag = '0;
      req1_valid = 1'b0; req1_aluop = '0; req1_a = '0; req1_b = '0; req1_tag = '0;
      rsp_ready = 1'b0;
      tick(); tick();

      // Reset state
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_alu_op", 32'(alu_op_o), 32'd0);
      chk("rst_alu_in1", alu_in1_o, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
      rst_n = 1'b1;
      tick();

      // Simple add from slot 0: 5 + 7, response in cycle 3
      req0_valid = 1'b1; req0_aluop = 5'd0; req0_a = 32'd5; req0_b = 32'd7; req0_tag = 4'd3;
      #1;
      chk("add_req0_ready", 32'(req0_ready), 32'd1);
      chk("add_req1_ready", 32'(req1_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      chk("add_in1", alu_in1_o, 32'd5);
      chk("add_in2", alu_in2_o, 32'd7);
      chk("add_c1_valid", 32'(rsp_valid), 32'd0);
      tick();
      chk("add_c2_valid", 32'(rsp_valid), 32'd0);
      tick();
      chk("add_c3_valid", 32'(rsp_valid), 32'd1);
      chk("add_id", 32'(rsp_id), 32'd0);
      chk("add_tag", 32'(rsp_tag), 32'd3);
      chk("add_data", rsp_data, 32'd12);
      chk("add_err", 32'(rsp_err), 32'd0);

      // Back-pressure: response held while a div request waits on slot 1
      req1_valid = 1'b1; req1_aluop = 5'd24; req1_a = 32'hFFFF_FFEC; req1_b = 32'd3; req1_tag = 4'd5;
      #1;
      chk("stall_req1_ready", 32'(req1_ready), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_valid", 32'(rsp_valid), 32'd1);
         chk("stall_data", rsp_data, 32'd12);
         chk("stall_tag", 32'(rsp_tag), 32'd3);
         chk("stall_req1_ready", 32'(req1_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      #1;
      chk("hs_req1_ready", 32'(req1_ready), 32'd0);
      tick();
      rsp_ready = 1'b0;
      chk("post_hs_valid", 32'(rsp_valid), 32'd0);
      chk("post_hs_req1_ready", 32'(req1_ready), 32'd1);
      chk("post_hs_req0_ready", 32'(req0_ready), 32'd0);

      // Divide -20 / 3: operands stable cycles 1..9, response in cycle 10
      tick();
      req1_valid = 1'b0;
      chk("div_op", 32'(alu_op_o), 32'd24);
      chk("div_in1", alu_in1_o, 32'hFFFF_FFEC);
      chk("div_in2", alu_in2_o, 32'd3);
      for (int c = 2; c <= 9; c++) begin
         tick();
         chk("div_hold_in1", alu_in1_o, 32'hFFFF_FFEC);
         chk("div_hold_in2", alu_in2_o, 32'd3);
         chk("div_hold_valid", 32'(rsp_valid), 32'd0);
      end
      tick();
      chk("div_valid", 32'(rsp_valid), 32'd1);
      chk("div_id", 32'(rsp_id), 32'd1);
      chk("div_tag", 32'(rsp_tag), 32'd5);
      chk("div_data", rsp_data, 32'hFFFF_FFFA);
      chk("div_err", 32'(rsp_err), 32'd0);
      rsp_ready = 1'b1;
      tick();

      // Continuous two-slot demand after a slot-1 grant: 0,1,0,1
      req0_valid = 1'b1; req0_aluop = 5'd1; req0_a = 32'd100; req0_b = 32'd1; req0_tag = 4'd1;
      req1_valid = 1'b1; req1_aluop = 5'd0; req1_a = 32'd200; req1_b = 32'd2; req1_tag = 4'd2;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("alt_req0_ready", 32'(req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("alt_req1_ready", 32'(req1_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
         tick(); tick(); tick();
         chk("alt_valid", 32'(rsp_valid), 32'd1);
         chk("alt_id", 32'(k % 2), 32'(rsp_id));
         chk("alt_data", rsp_data, (k % 2 == 0) ? 32'd99 : 32'd202);
         tick();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // Illegal opcode 12 from slot 0: error response next cycle, ALU inputs untouched
      req0_valid = 1'b1; req0_aluop = 5'd12; req0_a = 32'h111; req0_b = 32'h222; req0_tag = 4'd9;
      #1;
      chk("ill_req0_ready", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      chk("ill_valid", 32'(rsp_valid), 32'd1);
      chk("ill_err", 32'(rsp_err), 32'd1);
      chk("ill_data", rsp_data, 32'd0);
      chk("ill_tag", 32'(rsp_tag), 32'd9);
      chk("ill_id", 32'(rsp_id), 32'd0);
      chk("ill_alu_op", 32'(alu_op_o), 32'd0);
      chk("ill_alu_in1", alu_in1_o, 32'd200);
      chk("ill_alu_in2", alu_in2_o, 32'd2);
      tick();
      chk("ill_done", 32'(rsp_valid), 32'd0);

      // Reset during EXEC of a multiply abandons it
      req1_valid = 1'b1; req1_aluop = 5'd22; req1_a = 32'd6; req1_b = 32'd7; req1_tag = 4'd4;
      #1;
      chk("mulrst_req1_ready", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      chk("mulrst_op", 32'(alu_op_o), 32'd22);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mulrst_valid", 32'(rsp_valid), 32'd0);
      chk("mulrst_alu_op", 32'(alu_op_o), 32'd0);
      chk("mulrst_tag", 32'(rsp_tag), 32'd0);
      tick(); tick();
      chk("mulrst_no_rsp", 32'(rsp_valid), 32'd0);

      // Pointer back at 0 after reset: tie goes to slot 1, then multiply 6*7
      req0_valid = 1'b1; req0_aluop = 5'd0; req0_a = 32'd1; req0_b = 32'd1; req0_tag = 4'd8;
      req1_valid = 1'b1;
      #1;
      chk("ptr_req1_ready", 32'(req1_ready), 32'd1);
      chk("ptr_req0_ready", 32'(req0_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick(); tick();
      chk("mul_c3_valid", 32'(rsp_valid), 32'd0);
      tick();
      chk("mul_valid", 32'(rsp_valid), 32'd1);
      chk("mul_id", 32'(rsp_id), 32'd1);
      chk("mul_tag", 32'(rsp_tag), 32'd4);
      chk("mul_data", rsp_data, 32'd42);
      tick();

`ifdef ALU_SEQ_FLUSH_EN
      // Flush during EXEC drops the op; flush in IDLE blocks grants
      req0_valid = 1'b1; req0_aluop = 5'd0; req0_a = 32'd1; req0_b = 32'd2; req0_tag = 4'd6;
      flush = 1'b1;
      #1;
      chk("fl_idle_ready", 32'(req0_ready), 32'd0);
      flush = 1'b0;
      #1;
      chk("fl_req0_ready", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("fl_no_rsp", 32'(rsp_valid), 32'd0);
         tick();
      end
      req1_valid = 1'b1; req1_aluop = 5'd0; req1_a = 32'd3; req1_b = 32'd4; req1_tag = 4'd7;
      #1;
      chk("fl_next_ready", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      tick(); tick();
      chk("fl_next_data", rsp_data, 32'd7);
      tick();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
